membus_dma: RTL and testbench
=============================

Name: membus_dma

Overview:
- Native-bus initiator: copies a block of 32-bit words from a source to a destination address over the PicoRV32-style valid/ready memory bus.
- It is the master end of the interface that the on-chip RAM, UART and GPIO already answer as responders.
- It sits beside the CPU behind a bus arbiter. It frees the core from bulk copies, for example moving command tables from RAM into peripherals.
- Start, addresses and length come from a control register block. Completion and error are reported back as status bits.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles mem_valid may wait for mem_ready before the transfer aborts. Range 1..65535.
- LEN_W, 16: width of the word-count field.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  single-cycle request; sampled only in IDLE
- src_addr  in  32  source byte address; bits [1:0] ignored
- dst_addr  in  32  destination byte address; bits [1:0] ignored
- word_cnt  in  LEN_W  number of words to copy
- busy  out  1  high from the cycle after an accepted start until the cycle DONE or ERR is entered
- done  out  1  one-cycle pulse on normal completion
- err  out  1  sticky timeout flag; cleared by the next accepted start
- xfer_cnt  out  LEN_W  words completely written so far
- mem_valid  out  1  transaction request
- mem_instr  out  1  constant 0
- mem_addr  out  32  word-aligned address
- mem_wdata  out  32  write data
- mem_wstrb  out  4  4'b1111 on writes, 4'b0000 on reads
- mem_ready  in  1  responder acknowledge; may be combinational or registered
- mem_rdata  in  32  read data, valid while mem_ready is high

Behaviour:
- Reset values: all outputs 0. FSM in IDLE, internal counters 0. Reset acts immediately and asynchronously.
- A reset in mid-transfer drops mem_valid at once. No completion pulse follows.
- FSM states: IDLE, RD_REQ, RD_GAP, WR_REQ, WR_GAP, DONE, ERR.
- IDLE, start=1, word_cnt!=0:
  - Latch {src[31:2],2'b00}, {dst[31:2],2'b00} and word_cnt.
  - Clear err and xfer_cnt. Set busy. Go to RD_REQ.
- IDLE, start=1, word_cnt=0: go to DONE. No bus activity. err is cleared.
- start while not in IDLE: ignored.
- RD_REQ:
  - mem_valid=1, mem_addr=current source address, mem_wstrb=0.
  - A handshake completes on a rising edge where mem_valid && mem_ready.
  - On that edge, capture mem_rdata, advance source by 4 (wraps modulo 2^32), go to RD_GAP.
- RD_GAP: mem_valid=0 for exactly one cycle, then go to WR_REQ. The gap guarantees that registered responders, whose enable is gated by !mem_ready, see a fresh request.
- WR_REQ:
  - mem_valid=1, mem_addr=current destination address, mem_wdata=captured word, mem_wstrb=4'b1111.
  - On handshake: destination +4 (wraps), xfer_cnt +1.
  - If xfer_cnt+1 == latched count, go to DONE; else go to WR_GAP.
- WR_GAP: mem_valid=0 for one cycle, then go to RD_REQ.
- Bus stability: mem_addr, mem_wdata and mem_wstrb stay constant while mem_valid is high and mem_ready has not yet been seen.
- Throughput: a zero-wait responder gives 4 cycles per word (request, gap, request, gap). The last word takes 3 cycles plus the DONE cycle.
- Timeout:
  - A cycle counter resets on entry to each REQ state and increments every cycle mem_valid is high without mem_ready.
  - On the edge where the counter reaches TIMEOUT_CYCLES with mem_ready still low, go to ERR.
- ERR: mem_valid=0, err=1, busy=0, no done pulse. Returns to IDLE on the next cycle. err stays set.
- DONE: done=1 for one cycle, busy=0, then IDLE. xfer_cnt holds its final value until the next accepted start.
- Simultaneous mem_ready and timeout in the same cycle: the handshake wins and no error is raised.
- mem_ready while mem_valid is low (gap, IDLE): ignored.

Decomposition:
- Shared package membus_pkg holds:
  - the state enum;
  - WSTRB_RD=4'b0000 and WSTRB_WR=4'b1111;
  - ADDR_STEP=4.
- One natural sub-module, membus_timeout: a loadable counter with clear/enable inputs and an expire output. It is reusable by other bus initiators.
- Everything else stays in one module.

Test Plan:
- Zero-wait RAM model: src=0x1000, dst=0x2000, word_cnt=3, source 0xA0,0xA1,0xA2.
  - Required: dst holds the same three words; done pulses at cycle 12 after start; xfer_cnt=3; err=0.
- Responder inserting 2 wait states per access, word_cnt=2.
  - Required: bus fields stay stable across wait cycles; copy is correct; exactly 2 reads and 2 writes are seen.
- Responder never asserts mem_ready, TIMEOUT_CYCLES=8.
  - Required: ERR after 8 cycles of mem_valid; err=1, busy=0, no done; the next start with a good responder clears err.
- word_cnt=0 → done pulses one cycle after start, mem_valid never asserts. Also src=0xFFFFFFFC, word_cnt=2 → second read address is 0x00000000.
- Start pulsed during a transfer is ignored. resetn driven low mid-WR_REQ drops mem_valid within the same cycle with no clock edge. All outputs read 0 after reset.

Source files
------------

// File: rtl/membus_pkg.sv
// Shared types and constants for native valid/ready bus initiators.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: DMA state enum, write-strobe encodings, per-word address step.
package membus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_GAP,
    WR_REQ,
    WR_GAP,
    DONE,
    ERR
  } state_t;

  localparam logic [3:0]  WSTRB_RD  = 4'b0000;
  localparam logic [3:0]  WSTRB_WR  = 4'b1111;
  localparam logic [31:0] ADDR_STEP = 32'd4;

endpackage

// File: rtl/membus_timeout.sv
// Wait-cycle watchdog for a bus request: counts stalled cycles, flags expiry.
// Latency: expire is combinational on the cycle the count would reach limit.
// Backpressure: none; en is asserted by the owner while its request is stalled.
//
// Ports: clk, resetn (async active-low); clr zeroes the count and wins over en;
//        en increments; limit is the stall budget (>= 1); expire is high
//        during the stalled cycle whose closing edge would bring the count to limit.
module membus_timeout #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic             expire
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Look one step ahead so the owner can change state on the very edge the
  // count reaches limit.
  assign expire = en && (cnt_q == limit - 1'b1);

endmodule

// File: rtl/membus_dma.sv
// Word-copy DMA initiator on the native valid/ready memory bus.
// Latency: 4 cycles per word with a zero-wait responder; last word 3 cycles + DONE.
// Backpressure: holds each request stable until mem_ready; aborts to ERR after
//               TIMEOUT_CYCLES stalled cycles.
//
// Ports: clk, resetn; control start/src_addr/dst_addr/word_cnt; status
//        busy/done/err/xfer_cnt; bus mem_valid/mem_instr/mem_addr/mem_wdata/
//        mem_wstrb (out), mem_ready/mem_rdata (in).
module membus_dma
  import membus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int LEN_W          = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] word_cnt,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [LEN_W-1:0] xfer_cnt,
  output logic             mem_valid,
  output logic             mem_instr,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_wstrb,
  input  logic             mem_ready,
  input  logic [31:0]      mem_rdata
);

  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);

  state_t           state_q, state_d;
  logic [31:0]      src_q, dst_q, data_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] xfer_nxt;
  logic             in_req;
  logic             tmo_expire;

  assign xfer_nxt  = xfer_cnt + 1'b1;
  assign in_req    = (state_q == RD_REQ) || (state_q == WR_REQ);
  assign busy      = (state_q == RD_REQ) || (state_q == RD_GAP) ||
                     (state_q == WR_REQ) || (state_q == WR_GAP);
  assign done      = (state_q == DONE);
  assign mem_instr = 1'b0;

  // Held clear outside request states, so every request starts from zero.
  membus_timeout #(.CNT_W(16)) u_timeout (
    .clk    (clk),
    .resetn (resetn),
    .clr    (!in_req),
    .en     (mem_valid && !mem_ready),
    .limit  (TMO_LIMIT),
    .expire (tmo_expire)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Bus outputs are decoded from state_q only, so a reset drops mem_valid
  // immediately and the fields cannot move while a request waits.
  always_comb begin
    state_d   = state_q;
    mem_valid = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    mem_wstrb = WSTRB_RD;
    case (state_q)
      IDLE: begin
        if (start) state_d = (word_cnt == '0) ? DONE : RD_REQ;
      end
      RD_REQ: begin
        mem_valid = 1'b1;
        mem_addr  = src_q;
        // Handshake takes priority over a simultaneous timeout.
        if (mem_ready)       state_d = RD_GAP;
        else if (tmo_expire) state_d = ERR;
      end
      RD_GAP: state_d = WR_REQ;
      WR_REQ: begin
        mem_valid = 1'b1;
        mem_addr  = dst_q;
        mem_wdata = data_q;
        mem_wstrb = WSTRB_WR;
        if (mem_ready)       state_d = (xfer_nxt == len_q) ? DONE : WR_GAP;
        else if (tmo_expire) state_d = ERR;
      end
      WR_GAP:  state_d = RD_REQ;
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      src_q    <= '0;
      dst_q    <= '0;
      data_q   <= '0;
      len_q    <= '0;
      xfer_cnt <= '0;
      err      <= 1'b0;
    end else begin
      if (state_q == IDLE && start) begin
        src_q    <= src_addr & ~32'h3;
        dst_q    <= dst_addr & ~32'h3;
        len_q    <= word_cnt;
        xfer_cnt <= '0;
        err      <= 1'b0;
      end
      if (state_q == RD_REQ && mem_ready) begin
        data_q <= mem_rdata;
        src_q  <= src_q + ADDR_STEP;
      end
      if (state_q == WR_REQ && mem_ready) begin
        dst_q    <= dst_q + ADDR_STEP;
        xfer_cnt <= xfer_nxt;
      end
      if (state_d == ERR) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_membus_dma.sv
// Directed bench for membus_dma with a small memory responder model.
// Latency: n/a.
// Backpressure: responder mode selects zero-wait, two wait states, or never ready.
module tb_membus_dma;

  logic        clk;
  logic        resetn;
  logic        start;
  logic [31:0] src_addr, dst_addr;
  logic [15:0] word_cnt;
  logic        busy, done, err;
  logic [15:0] xfer_cnt;
  logic        mem_valid, mem_instr, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  membus_dma #(.TIMEOUT_CYCLES(8), .LEN_W(16)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .word_cnt  (word_cnt),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .xfer_cnt  (xfer_cnt),
    .mem_valid (mem_valid),
    .mem_instr (mem_instr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Responder: 32-word memory indexed by address bits {13:12, 4:2}.
  logic [31:0] mem [32];
  logic [1:0]  resp_mode;   // 0 zero-wait, 1 two wait states, 2 never ready
  logic [1:0]  wcnt;
  logic [4:0]  mem_idx;
  logic        cnt_clr;
  int          rd_cnt, wr_cnt, stab_err;
  logic [31:0] rd_log [4];
  logic        hold_vld;
  logic [31:0] hold_addr, hold_wdata;
  logic [3:0]  hold_wstrb;

  assign mem_idx   = {mem_addr[13:12], mem_addr[4:2]};
  assign mem_ready = mem_valid && ((resp_mode == 2'd0) ||
                                   (resp_mode == 2'd1 && wcnt == 2'd2));
  assign mem_rdata = mem[mem_idx];

  always @(posedge clk) begin
    if (mem_valid && !mem_ready) wcnt <= wcnt + 2'd1;
    else                         wcnt <= 2'd0;
    if (mem_valid && mem_ready && mem_wstrb == 4'hF) mem[mem_idx] = mem_wdata;
    if (cnt_clr) begin
      rd_cnt   <= 0;
      wr_cnt   <= 0;
      stab_err <= 0;
    end else if (mem_valid && mem_ready) begin
      if (mem_wstrb == 4'h0) begin
        if (rd_cnt < 4) rd_log[rd_cnt] <= mem_addr;
        rd_cnt <= rd_cnt + 1;
      end else begin
        wr_cnt <= wr_cnt + 1;
      end
    end
    if (mem_valid && !mem_ready) begin
      if (hold_vld && (mem_addr != hold_addr || mem_wdata != hold_wdata ||
                       mem_wstrb != hold_wstrb))
        stab_err <= stab_err + 1;
      hold_vld   <= 1'b1;
      hold_addr  <= mem_addr;
      hold_wdata <= mem_wdata;
      hold_wstrb <= mem_wstrb;
    end else begin
      hold_vld <= 1'b0;
    end
  end

  int n_chk, n_pass;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
  endtask

  task automatic clr_counts();
    @(negedge clk);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
  endtask

  // Issues a start, then samples each cycle on the falling edge until done or
  // err is seen (cycle index 1 = first cycle after the accepting edge).
  // At cycle 'poke' a conflicting start is pulsed.
  task automatic run_xfer(input logic [31:0] s, input logic [31:0] d,
                          input logic [15:0] n, input int poke,
                          output int done_c, output int err_c, output int vcyc,
                          output logic busy1, output logic err1);
    @(negedge clk);
    src_addr = s;
    dst_addr = d;
    word_cnt = n;
    start    = 1'b1;
    done_c = 0;
    err_c  = 0;
    vcyc   = 0;
    busy1  = 1'b0;
    err1   = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      start = (c == poke);
      if (c == poke) begin
        word_cnt = 16'd5;
        src_addr = 32'h0000_3000;
      end
      if (c == 1) begin
        busy1 = busy;
        err1  = err;
      end
      if (mem_valid) vcyc++;
      if (done) begin done_c = c; break; end
      if (err)  begin err_c  = c; break; end
    end
    start = 1'b0;
  endtask

  int   dc, ec, vc;
  logic b1, e1;
  logic found;
  logic saw_done;

  initial begin
    n_chk = 0; n_pass = 0;
    resetn = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; word_cnt = '0;
    resp_mode = 2'd0; wcnt = 2'd0; cnt_clr = 1'b1;
    hold_vld = 1'b0; hold_addr = '0; hold_wdata = '0; hold_wstrb = '0;
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    for (int i = 0; i < 4; i++) rd_log[i] = 32'h0;
    mem[8] = 32'hA0; mem[9] = 32'hA1; mem[10] = 32'hA2;
    mem[31] = 32'hB0; mem[0] = 32'hB1;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {busy, done, err, mem_valid, mem_instr, mem_wstrb, xfer_cnt}, 32'h0);
    chk("rst_addr", mem_addr | mem_wdata, 32'h0);
    resetn = 1'b1;
    cnt_clr = 1'b0;

    // Zero-wait copy of three words.
    clr_counts();
    run_xfer(32'h1000, 32'h2000, 16'd3, 0, dc, ec, vc, b1, e1);
    chk("t1_done_cycle", dc, 12);
    chk("t1_busy_c1", {31'b0, b1}, 1);
    chk("t1_xfer_cnt", {16'b0, xfer_cnt}, 3);
    chk("t1_err", {31'b0, err}, 0);
    chk("t1_valid_cycles", vc, 6);
    chk("t1_dst0", mem[16], 32'hA0);
    chk("t1_dst1", mem[17], 32'hA1);
    chk("t1_dst2", mem[18], 32'hA2);
    @(negedge clk);
    chk("t1_xfer_hold", {16'b0, xfer_cnt}, 3);

    // Two wait states per access.
    resp_mode = 2'd1;
    clr_counts();
    run_xfer(32'h1000, 32'h2010, 16'd2, 0, dc, ec, vc, b1, e1);
    chk("t2_done_cycle", dc, 16);
    chk("t2_reads", rd_cnt, 2);
    chk("t2_writes", wr_cnt, 2);
    chk("t2_stable", stab_err, 0);
    chk("t2_dst0", mem[20], 32'hA0);
    chk("t2_dst1", mem[21], 32'hA1);

    // Responder never answers: timeout after 8 valid cycles.
    resp_mode = 2'd2;
    clr_counts();
    run_xfer(32'h1000, 32'h2000, 16'd2, 0, dc, ec, vc, b1, e1);
    chk("t3_no_done", dc, 0);
    chk("t3_err_cycle", ec, 9);
    chk("t3_valid_cycles", vc, 8);
    chk("t3_busy", {31'b0, busy}, 0);
    chk("t3_xfer_cnt", {16'b0, xfer_cnt}, 0);
    @(negedge clk);
    chk("t3_err_sticky", {31'b0, err}, 1);
    chk("t3_done_low", {31'b0, done}, 0);
    resp_mode = 2'd0;
    run_xfer(32'h1008, 32'h2018, 16'd1, 0, dc, ec, vc, b1, e1);
    chk("t3_err_cleared", {31'b0, e1}, 0);
    chk("t3_recover_done", dc, 4);
    chk("t3_recover_data", mem[22], 32'hA2);

    // Zero-length request.
    clr_counts();
    run_xfer(32'h1000, 32'h2000, 16'd0, 0, dc, ec, vc, b1, e1);
    chk("t4_zero_done", dc, 1);
    chk("t4_zero_valid", vc, 0);
    chk("t4_zero_reads", rd_cnt, 0);

    // Source address wraps past 0xFFFFFFFC.
    clr_counts();
    run_xfer(32'hFFFF_FFFC, 32'h2000, 16'd2, 0, dc, ec, vc, b1, e1);
    chk("t4_wrap_rd0", rd_log[0], 32'hFFFF_FFFC);
    chk("t4_wrap_rd1", rd_log[1], 32'h0000_0000);
    chk("t4_wrap_dst0", mem[16], 32'hB0);
    chk("t4_wrap_dst1", mem[17], 32'hB1);

    // Start pulsed mid-transfer is ignored.
    run_xfer(32'h1000, 32'h2000, 16'd2, 3, dc, ec, vc, b1, e1);
    chk("t5_poke_done", dc, 8);
    chk("t5_poke_xfer", {16'b0, xfer_cnt}, 2);
    chk("t5_poke_dst1", mem[17], 32'hA1);

    // Asynchronous reset while a write request is pending.
    resp_mode = 2'd1;
    @(negedge clk);
    src_addr = 32'h1000; dst_addr = 32'h2010; word_cnt = 16'd1; start = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (mem_valid && mem_wstrb == 4'hF) begin found = 1'b1; break; end
    end
    chk("t5_wr_req_seen", {31'b0, found}, 1);
    #1 resetn = 1'b0;
    #1;
    chk("t5_rst_valid", {31'b0, mem_valid}, 0);
    chk("t5_rst_outputs", {busy, done, err, mem_instr, mem_wstrb, xfer_cnt}, 32'h0);
    chk("t5_rst_addr", mem_addr | mem_wdata, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    saw_done = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done || mem_valid) saw_done = 1'b1;
    end
    chk("t5_post_rst_quiet", {31'b0, saw_done}, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
